// File: rtl/ps2_mouse_decoder_if.sv
// Packet-side bus of the PS/2 mouse decoder: decoded deltas, buttons and status
// pulses toward the console, plus the consumer's acknowledge back.
interface ps2_mouse_decoder_if;
  logic       i_ack;
  logic [7:0] o_mouse_x;
  logic       o_is_mouse_x_neg;
  logic [7:0] o_mouse_y;
  logic       o_is_mouse_y_neg;
  logic       o_btn_left;
  logic       o_btn_right;
  logic       o_btn_middle;
  logic       o_valid;
  logic       o_frame_err;

  modport master (
    input  i_ack,
    output o_mouse_x, o_is_mouse_x_neg, o_mouse_y, o_is_mouse_y_neg,
           o_btn_left, o_btn_right, o_btn_middle, o_valid, o_frame_err
  );

  modport slave (
    output i_ack,
    input  o_mouse_x, o_is_mouse_x_neg, o_mouse_y, o_is_mouse_y_neg,
           o_btn_left, o_btn_right, o_btn_middle, o_valid, o_frame_err
  );
endinterface

// File: rtl/ps2_mouse_decoder.sv
// PS/2 mouse receiver: conditions the raw clock/data pins, deserialises 11-bit
// frames and assembles 3-byte stream packets into sign-magnitude deltas.
module ps2_mouse_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic                       clk,
  input  logic                       arst_n,
  input  logic                       i_ps2_clk,
  input  logic                       i_ps2_data,
  ps2_mouse_decoder_if.master        mif
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {WAIT_B0, WAIT_B1, WAIT_B2} state_t;

  logic [1:0]    ck_s, dt_s;
  logic          ck_f, ck_f_d;
  logic [FW-1:0] flt_cnt;
  logic          strobe;
  logic          dt;

  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_q;
  state_t        state;
  logic [7:0]    b0_q, x_q;
  logic [TW-1:0] idle_cnt;

  logic          stop_cyc, byte_ok, byte_bad, timeout, commit_now, err_now;
  logic [8:0]    x_cv, y_cv;

  // Synchronise both pins and debounce the clock; idle bus level is 1.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      ck_s    <= 2'b11;
      dt_s    <= 2'b11;
      ck_f    <= 1'b1;
      ck_f_d  <= 1'b1;
      flt_cnt <= '0;
    end else begin
      ck_s   <= {ck_s[0], i_ps2_clk};
      dt_s   <= {dt_s[0], i_ps2_data};
      ck_f_d <= ck_f;
      if (ck_s[1] != ck_f) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          ck_f    <= ck_s[1];
          flt_cnt <= '0;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  assign strobe = ck_f_d & ~ck_f;
  assign dt     = dt_s[1];

  // {neg, magnitude}; only sign=1 with byte 0x00 (-256) needs saturating.
  function automatic logic [8:0] conv(input logic sgn, input logic ovf, input logic [7:0] b);
    logic [7:0] m;
    if (ovf)           m = 8'hFF;
    else if (!sgn)     m = b;
    else if (b == '0)  m = 8'hFF;
    else               m = ~b + 8'd1;
    return {sgn & (m != 8'd0), m};
  endfunction

  assign stop_cyc   = strobe && (bit_cnt == 4'd10);
  assign byte_ok    = stop_cyc && dt && (^{shreg, par_q});
  assign byte_bad   = (strobe && (bit_cnt == 4'd0) && dt) || (stop_cyc && !byte_ok);
  assign timeout    = !strobe && (idle_cnt == TW'(TIMEOUT_CYCLES - 1)) &&
                      ((bit_cnt != 4'd0) || (state != WAIT_B0));
  assign commit_now = byte_ok && (state == WAIT_B2);
  assign err_now    = byte_bad || timeout || (byte_ok && (state == WAIT_B0) && !shreg[3]);
  assign x_cv       = conv(b0_q[4], b0_q[6], x_q);
  assign y_cv       = conv(b0_q[5], b0_q[7], shreg);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      bit_cnt              <= '0;
      shreg                <= '0;
      par_q                <= 1'b0;
      state                <= WAIT_B0;
      b0_q                 <= '0;
      x_q                  <= '0;
      idle_cnt             <= '0;
      mif.o_mouse_x        <= '0;
      mif.o_is_mouse_x_neg <= 1'b0;
      mif.o_mouse_y        <= '0;
      mif.o_is_mouse_y_neg <= 1'b0;
      mif.o_btn_left       <= 1'b0;
      mif.o_btn_right      <= 1'b0;
      mif.o_btn_middle     <= 1'b0;
      mif.o_valid          <= 1'b0;
      mif.o_frame_err      <= 1'b0;
    end else begin
      // Idle counter saturates so a stuck-idle link reports a timeout once.
      if (strobe)
        idle_cnt <= '0;
      else if (idle_cnt != TW'(TIMEOUT_CYCLES))
        idle_cnt <= idle_cnt + 1'b1;

      if (strobe) begin
        case (bit_cnt)
          4'd0:    if (!dt) bit_cnt <= 4'd1;
          4'd9:    begin par_q <= dt; bit_cnt <= 4'd10; end
          4'd10:   bit_cnt <= 4'd0;
          default: begin shreg <= {dt, shreg[7:1]}; bit_cnt <= bit_cnt + 4'd1; end
        endcase
      end else if (timeout) begin
        bit_cnt <= 4'd0;
      end

      if (byte_bad || timeout) begin
        state <= WAIT_B0;
      end else if (byte_ok) begin
        case (state)
          WAIT_B0: if (shreg[3]) begin b0_q <= shreg; state <= WAIT_B1; end
          WAIT_B1: begin x_q <= shreg; state <= WAIT_B2; end
          default: state <= WAIT_B0;
        endcase
      end

      // A commit outranks a same-cycle acknowledge.
      if (commit_now) begin
        mif.o_mouse_x        <= x_cv[7:0];
        mif.o_is_mouse_x_neg <= x_cv[8];
        mif.o_mouse_y        <= y_cv[7:0];
        mif.o_is_mouse_y_neg <= y_cv[8];
        mif.o_btn_left       <= b0_q[0];
        mif.o_btn_right      <= b0_q[1];
        mif.o_btn_middle     <= b0_q[2];
      end else if (mif.i_ack) begin
        mif.o_mouse_x        <= '0;
        mif.o_is_mouse_x_neg <= 1'b0;
        mif.o_mouse_y        <= '0;
        mif.o_is_mouse_y_neg <= 1'b0;
      end

      mif.o_valid     <= commit_now;
      mif.o_frame_err <= err_now;
    end
  end

endmodule

// File: doc/ps2_mouse_decoder.md
Name: ps2_mouse_decoder

Overview:
- Receive side of the PS/2 mouse link. Deserialises device-to-host frames from the raw PS/2 clock and data lines and assembles standard 3-byte stream-mode packets.
- Presents each packet as sign-magnitude X/Y deltas plus button states, in the form the console top consumes (mouse_x/is_mouse_x_neg, mouse_y/is_mouse_y_neg).
- Sits between the board PS/2 pins and game_console.

Parameters:
- FILTER_LEN, 4, consecutive identical clk samples required before the filtered PS/2 clock changes.
- TIMEOUT_CYCLES, 20000, idle cycles without a filtered falling edge before a partial frame or packet is discarded.

Ports:
- clk  in  1  system clock
- arst_n  in  1  reset, asynchronous, active-low
- i_ps2_clk  in  1  raw PS/2 clock, asynchronous to clk
- i_ps2_data  in  1  raw PS/2 data, asynchronous to clk
- i_ack  in  1  consumer has used the current deltas; clears them
- o_mouse_x  out  8  X delta magnitude
- o_is_mouse_x_neg  out  1  X delta sign
- o_mouse_y  out  8  Y delta magnitude, PS/2 convention (positive = up, no inversion)
- o_is_mouse_y_neg  out  1  Y delta sign
- o_btn_left / o_btn_right / o_btn_middle  out  1 each  button states from the last good packet
- o_valid  out  1  one-cycle pulse when the outputs update from a new packet
- o_frame_err  out  1  one-cycle pulse on any discarded byte or packet

Behaviour:
- Reset: all outputs 0; bit counter 0; packet FSM in WAIT_B0; filter and synchronisers set to 1 (idle bus).
- Input conditioning:
  - Each raw input passes a 2-FF synchroniser.
  - Filtered clock toggles only after FILTER_LEN consecutive samples differ from its current value.
  - Edge strobe fires on a filtered 1->0 transition.
  - Data is sampled from the synchronised data line in the strobe cycle.
- Frame, 11 bits, LSB first:
  - Start bit must be 0, followed by 8 data bits, odd parity over data+parity, stop bit must be 1.
  - Bit counter runs 0..10 and returns to 0 after the stop bit.
  - Bad start, parity or stop: discard the byte, pulse o_frame_err, force the FSM to WAIT_B0.
- Packet FSM:
  - WAIT_B0: byte bit3 must be 1, else discard, pulse o_frame_err, stay in WAIT_B0 (resync). Good byte -> WAIT_B1.
  - WAIT_B1: store as X byte -> WAIT_B2.
  - WAIT_B2: store as Y byte, commit -> WAIT_B0.
  - Byte0 fields: b0 left, b1 right, b2 middle, b4 X sign, b5 Y sign, b6 X overflow, b7 Y overflow.
- Delta conversion, per axis: v = {sign, byte}, 9-bit two's complement.
  - overflow=1: magnitude 255, neg = sign.
  - sign=0: magnitude = byte, neg = 0.
  - sign=1: magnitude = (-v)[7:0]; if byte == 0x00 (-256), magnitude saturates to 255; neg = 1.
  - Magnitude 0 always reports neg = 0.
- Latency: the strobe capturing byte 2's stop bit is cycle N. Outputs update and o_valid = 1 in cycle N+1 (registered).
- Holding and ack:
  - Deltas and buttons hold until the next commit.
  - i_ack=1 clears deltas and signs to 0 next cycle; buttons are unchanged.
  - Commit and i_ack in the same cycle: commit wins and new deltas are kept.
- Timeout:
  - The idle counter resets on every strobe.
  - If it reaches TIMEOUT_CYCLES while the bit counter is nonzero or the FSM is not in WAIT_B0: clear the bit counter, return to WAIT_B0, pulse o_frame_err once.
  - The counter saturates; no repeat pulses while idle.
- Reset mid-frame or mid-packet: all partial state is discarded with no pulses. The first complete frame after reset is treated as byte 0.
- o_valid and o_frame_err are never both high in the same cycle.

Test Plan:
- Bytes 0x29, 0x05, 0xFB with correct framing -> one o_valid pulse; x=5/neg 0; y=5/y_neg 1; left=1, right=0, middle=0; o_frame_err stays 0.
- Bytes 0x18, 0x00, 0x00 -> x=255/neg 1 (saturated -256); y=0/neg 0. Bytes 0x48, 0x10, 0x00 -> x=255/neg 0 (overflow).
- Frame with a bad parity bit as byte 1 -> o_frame_err pulse, no o_valid. A following good packet 0x08, 0x03, 0x02 decodes to x=3, y=2.
- Leading byte 0x05 (bit3=0) followed by 0x09, 0x01, 0x01 -> one o_frame_err, then o_valid with x=1, y=1, left=1.
- Send 0x09, 0x07, then idle > TIMEOUT_CYCLES -> one o_frame_err. Then 0x08, 0x02, 0x00 -> x=2 (not misaligned).
- i_ack asserted in the exact o_valid update cycle -> new deltas retained. i_ack one cycle later -> x=y=0, signs 0, buttons retained. arst_n pulsed mid-frame -> all outputs 0 and the next packet decodes correctly.
